// File: rtl/cp0_unit.sv
// Coprocessor-0 register file and exception/interrupt arbiter.
//
// Holds SR (12), Cause (13), EPC (14) and the constant PRId (15). Raises
// IntReq combinationally when an enabled hardware interrupt or an M-stage
// exception must be taken. Also serves mfc0 reads, mtc0 writes and eret.
//
// Ports:
//   clk      in   1   system clock, all state updates on posedge
//   reset    in   1   synchronous, active-high
//   A1       in   5   mfc0 read register number
//   A2       in   5   mtc0 write register number
//   DIn      in   32  mtc0 write data
//   WE       in   1   mtc0 write enable (M stage)
//   PC       in   32  PC of the M-stage instruction
//   BD       in   1   M-stage instruction sits in a branch delay slot
//   ExcCode  in   5   M-stage exception code, 0 = none
//   HWInt    in   6   hardware interrupt lines [7:2]
//   EXLClr   in   1   eret in M stage
//   IntReq   out  1   take interrupt/exception this cycle (combinational)
//   EPC      out  32  EPC register value (eret target)
//   DOut     out  32  mfc0 read data (combinational on A1)
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2020_0730
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    typedef enum logic {
        EXL_NORMAL  = 1'b0,
        EXL_HANDLER = 1'b1
    } exl_state_t;

    exl_state_t  r_exl_state;
    exl_state_t  w_exl_next;

    logic [5:0]  r_im;
    logic        r_ie;
    logic [5:0]  r_ip;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [29:0] r_epc;

    logic        w_exl;
    logic        w_int_irq;
    logic        w_exc_irq;
    logic        w_sr_we;
    logic        w_epc_we;
    logic [29:0] w_epc_target;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused_pc;

    // PC is word aligned; the low bits carry no information here.
    assign w_unused_pc = ^PC[1:0];

    assign w_exl     = (r_exl_state == EXL_HANDLER);
    // Interrupts look at the live HWInt lines, not the latched IP copy.
    assign w_int_irq = (|(HWInt & r_im)) & r_ie & ~w_exl;
    assign w_exc_irq = (ExcCode != 5'd0) & ~w_exl;
    assign IntReq    = w_int_irq | w_exc_irq;

    // mtc0 is squashed when the same instruction is being interrupted.
    assign w_sr_we  = WE & ~IntReq & (A2 == 5'd12);
    assign w_epc_we = WE & ~IntReq & (A2 == 5'd14);

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign w_epc_target = BD ? (PC[31:2] - 30'd1) : PC[31:2];

    assign w_sr    = {16'b0, r_im, 8'b0, w_exl, r_ie};
    assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b0};
    assign EPC     = {r_epc, 2'b00};

    always_comb begin
        DOut = '0;
        case (A1)
            5'd12:   DOut = w_sr;
            5'd13:   DOut = w_cause;
            5'd14:   DOut = {r_epc, 2'b00};
            5'd15:   DOut = PRID;
            default: DOut = '0;
        endcase
    end

    // Entry beats eret, and eret beats an mtc0 write of the EXL bit.
    always_comb begin
        w_exl_next = r_exl_state;
        if (IntReq) begin
            w_exl_next = EXL_HANDLER;
        end else if (EXLClr) begin
            w_exl_next = EXL_NORMAL;
        end else if (w_sr_we) begin
            w_exl_next = DIn[1] ? EXL_HANDLER : EXL_NORMAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exl_state <= EXL_NORMAL;
        end else begin
            r_exl_state <= w_exl_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_ie      <= 1'b0;
            r_ip      <= '0;
            r_bd      <= 1'b0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= HWInt;
            if (IntReq) begin
                r_exccode <= w_int_irq ? 5'd0 : ExcCode;
                r_bd      <= BD;
                r_epc     <= w_epc_target;
            end else begin
                if (w_sr_we) begin
                    r_im <= DIn[15:10];
                    r_ie <= DIn[0];
                end
                if (w_epc_we) begin
                    r_epc <= DIn[31:2];
                end
            end
        end
    end

endmodule
